ledger_writeback: RTL and testbench

Writes a completed transaction's two player balances back into the shared 11-bit ledger memory and returns a one-cycle completion strobe to the controller. It sits on the write side of the same memory whose read port feeds the transaction datapath. Ledger words carry a 3-bit tag in [10:8] (3'b101 player 1 balance, 3'b110 player 2 balance) and an 8-bit balance in [7:0]. The block sequences the two writes and can optionally read them back to confirm them.

---
 rtl/ledger_writeback.sv | 123 ++++++++++++
 tb/tb_ledger_writeback.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ledger_writeback.sv
// Writes a finished transaction's two tagged balance words into the ledger memory, then pulses done.
// Optional read-back confirmation of both writes is enabled with `define LEDGER_READBACK_EN.
module ledger_writeback #(
   parameter int                ADDR_W  = 5,
   parameter logic [ADDR_W-1:0] P1_ADDR = 5'd1,
   parameter logic [ADDR_W-1:0] P2_ADDR = 5'd2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic [10:0]       p1_amount_in,
   input  logic [10:0]       p2_amount_in,
   input  logic [10:0]       readback,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_address,
   output logic [10:0]       mem_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [2:0] TAG_P1 = 3'b101;
   localparam logic [2:0] TAG_P2 = 3'b110;

   typedef enum logic [2:0] {
      IDLE, WR_P1, WR_P2, RD_P1, CK_P1, RD_P2, CK_P2, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [10:0]       w1, w1_nxt;
   logic [10:0]       w2, w2_nxt;
   logic              error_nxt;
   logic              wren_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [10:0]       data_nxt;

   // Memory-side outputs are registered from the next state so they line up with the state occupied.
   always_comb begin
      state_nxt = state;
      w1_nxt    = w1;
      w2_nxt    = w2;
      error_nxt = error;
      wren_nxt  = 1'b0;
      addr_nxt  = mem_address;
      data_nxt  = mem_data;
      case (state)
         IDLE: begin
            if (start) begin
               w1_nxt    = {TAG_P1, p1_amount_in[7:0]};
               w2_nxt    = {TAG_P2, p2_amount_in[7:0]};
               error_nxt = 1'b0;
               if (p1_amount_in[10:8] != TAG_P1 || p2_amount_in[10:8] != TAG_P2) begin
                  error_nxt = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = WR_P1;
                  wren_nxt  = 1'b1;
                  addr_nxt  = P1_ADDR;
                  data_nxt  = {TAG_P1, p1_amount_in[7:0]};
               end
            end
         end
         WR_P1: begin
            state_nxt = WR_P2;
            wren_nxt  = 1'b1;
            addr_nxt  = P2_ADDR;
            data_nxt  = w2;
         end
         WR_P2: begin
`ifdef LEDGER_READBACK_EN
            state_nxt = RD_P1;
            addr_nxt  = P1_ADDR;
`else
            state_nxt = DONE;
`endif
         end
         RD_P1: state_nxt = CK_P1;
         // readback here reflects the address presented during RD_P1
         CK_P1: begin
            if (readback != w1) begin
               error_nxt = 1'b1;
               state_nxt = DONE;
            end else begin
               state_nxt = RD_P2;
               addr_nxt  = P2_ADDR;
            end
         end
         RD_P2: state_nxt = CK_P2;
         CK_P2: begin
            if (readback != w2) error_nxt = 1'b1;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         error       <= 1'b0;
         mem_wren    <= 1'b0;
         mem_address <= '0;
         mem_data    <= '0;
      end else begin
         state       <= state_nxt;
         error       <= error_nxt;
         mem_wren    <= wren_nxt;
         mem_address <= addr_nxt;
         mem_data    <= data_nxt;
      end
   end

   // Latched words only matter once a transaction is accepted, so they carry no reset.
   always_ff @(posedge clock) begin
      w1 <= w1_nxt;
      w2 <= w2_nxt;
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_ledger_writeback.sv
// Directed bench for ledger_writeback: vector table of transactions plus reset, held-start and read-back sequences.
module tb_ledger_writeback;

`ifdef LEDGER_READBACK_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [10:0] p1_amount_in = '0;
   logic [10:0] p2_amount_in = '0;
   logic [10:0] readback = '0;
   logic        mem_wren;
   logic [4:0]  mem_address;
   logic [10:0] mem_data;
   logic        busy;
   logic        done;
   logic        error;

   ledger_writeback #(.ADDR_W(5), .P1_ADDR(5'd1), .P2_ADDR(5'd2)) dut (
      .clock(clock), .resetn(resetn), .start(start),
      .p1_amount_in(p1_amount_in), .p2_amount_in(p2_amount_in), .readback(readback),
      .mem_wren(mem_wren), .mem_address(mem_address), .mem_data(mem_data),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   // Synchronous memory, 1-cycle read, write-through, optional corruption of one address.
   logic [10:0] mem [0:31];
   logic [4:0]  log_a [0:255];
   logic [10:0] log_d [0:255];
   int          wr_total = 0;
   int          corrupt_addr = 0;

   always @(posedge clock) begin
      if (mem_wren) begin
         mem[mem_address]  <= mem_data;
         log_a[wr_total]   <= mem_address;
         log_d[wr_total]   <= mem_data;
         wr_total          <= wr_total + 1;
      end
      if (corrupt_addr != 0 && int'(mem_address) == corrupt_addr) readback <= 11'h6FF;
      else if (mem_wren) readback <= mem_data;
      else readback <= mem[mem_address];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic run_txn(input string nm, input logic [10:0] p1, input logic [10:0] p2,
                          input int exp_err, input int exp_lat, input int exp_wr,
                          input logic [10:0] e1, input logic [10:0] e2);
      int base;
      int dc;
      base = wr_total;
      dc = 0;
      p1_amount_in = p1;
      p2_amount_in = p2;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk({nm, ".busy_c1"}, busy, 1);
      for (int c = 1; c <= 12 && dc == 0; c++) begin
         if (done) dc = c;
         else tick;
      end
      chk({nm, ".done_cycle"}, dc, exp_lat);
      chk({nm, ".error"}, error, exp_err);
      tick;
      chk({nm, ".done_one_cycle"}, done, 0);
      chk({nm, ".busy_after"}, busy, 0);
      chk({nm, ".error_sticky"}, error, exp_err);
      chk({nm, ".n_writes"}, wr_total - base, exp_wr);
      if (exp_wr == 2) begin
         chk({nm, ".wr0_addr"}, log_a[base], 1);
         chk({nm, ".wr0_data"}, log_d[base], e1);
         chk({nm, ".wr1_addr"}, log_a[base+1], 2);
         chk({nm, ".wr1_data"}, log_d[base+1], e2);
         chk({nm, ".data_held"}, mem_data, e2);
      end
   endtask

   typedef struct {
      logic [10:0] p1;
      logic [10:0] p2;
      int          err;
      int          lat;
      int          nwr;
      logic [10:0] w1;
      logic [10:0] w2;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d1, d2, nd, base, waited;
      vecs[0] = '{11'h53C, 11'h60A, 0, LAT, 2, 11'h53C, 11'h60A};
      vecs[1] = '{11'h5FF, 11'h600, 0, LAT, 2, 11'h5FF, 11'h600};
      vecs[2] = '{11'h000, 11'h60A, 1, 1,   0, 11'h000, 11'h000};
      vecs[3] = '{11'h53C, 11'h70A, 1, 1,   0, 11'h000, 11'h000};
      vecs[4] = '{11'h580, 11'h6FE, 0, LAT, 2, 11'h580, 11'h6FE};
      vecs[5] = '{11'h400, 11'h600, 1, 1,   0, 11'h000, 11'h000};

      // Reset
      resetn = 1'b0;
      tick;
      tick;
      chk("rst.mem_wren", mem_wren, 0);
      chk("rst.mem_address", mem_address, 0);
      chk("rst.mem_data", mem_data, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.error", error, 0);
      resetn = 1'b1;
      tick;

      for (int i = 0; i < 6; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2, vecs[i].err,
                 vecs[i].lat, vecs[i].nwr, vecs[i].w1, vecs[i].w2);

      // Bad tag, then a valid start clears error at the accept edge
      run_txn("badtag", 11'h000, 11'h000, 1, 1, 0, 11'h000, 11'h000);
      p1_amount_in = 11'h53C;
      p2_amount_in = 11'h60A;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("errclr.error", error, 0);
      waited = 0;
      while (!done && waited < 12) begin
         tick;
         waited++;
      end
      chk("errclr.done_seen", done, 1);
      tick;

      // start held high: one transaction per IDLE visit
      d1 = 0;
      d2 = 0;
      nd = 0;
      start = 1'b1;
      tick;
      for (int c = 1; c <= 2*LAT + 2; c++) begin
         if (done) begin
            if (nd == 0) d1 = c;
            else if (nd == 1) d2 = c;
            nd++;
         end
         tick;
      end
      start = 1'b0;
      chk("held.first_done", d1, LAT);
      chk("held.second_done", d2, 2*LAT + 1);
      chk("held.n_done", nd, 2);
      waited = 0;
      while (busy && waited < 20) begin
         tick;
         waited++;
      end
      chk("held.idle", busy, 0);
      tick;

      // Reset asserted during WR_P1: only the P1 write lands
      base = wr_total;
      p1_amount_in = 11'h511;
      p2_amount_in = 11'h622;
      start = 1'b1;
      tick;
      start = 1'b0;
      resetn = 1'b0;
      tick;
      chk("midrst.mem_wren", mem_wren, 0);
      chk("midrst.mem_address", mem_address, 0);
      chk("midrst.mem_data", mem_data, 0);
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.error", error, 0);
      resetn = 1'b1;
      nd = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) nd++;
         tick;
      end
      chk("midrst.no_done", nd, 0);
      chk("midrst.n_writes", wr_total - base, 1);
      chk("midrst.wr_addr", log_a[base], 1);
      chk("midrst.wr_data", log_d[base], 11'h511);

`ifdef LEDGER_READBACK_EN
      corrupt_addr = 2;
      run_txn("corrupt_p2", 11'h53C, 11'h60A, 1, 7, 2, 11'h53C, 11'h60A);
      corrupt_addr = 1;
      run_txn("corrupt_p1", 11'h53C, 11'h60A, 1, 5, 2, 11'h53C, 11'h60A);
      corrupt_addr = 0;
      run_txn("clean_rb", 11'h501, 11'h602, 0, 7, 2, 11'h501, 11'h602);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
